// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the cnn pipeline stages.
// CONV_OUT_SIZE is the conv layer's feature-map edge length.
package cnn_pkg;

    localparam int unsigned DATA_W           = 32;
    localparam int unsigned CONV_FILTER_SIZE = 3;
    localparam int unsigned CONV_STRIDE      = 2;
    localparam int unsigned CONV_NUM_FILTERS = 16;
    localparam int unsigned INPUT_SIZE       = 28;
    localparam int unsigned CONV_OUT_SIZE    =
        ((INPUT_SIZE - CONV_FILTER_SIZE) / CONV_STRIDE) + 1;

    typedef logic signed [DATA_W-1:0] data_t;

    function automatic data_t smax(input data_t a, input data_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row store of horizontal pair maxima for the max-pool stage.
// One write port, one combinational read port, cleared on reset.
module pool_line_buf #(
    parameter int unsigned  DATA_W = 32,
    parameter int unsigned  DEPTH  = 6,
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/relu_maxpool_stream.sv
// Streaming ReLU + 2x2/stride-2 max-pool over raster-ordered feature maps.
// Holds one half-row of pair maxima; output is a single valid/ready register.
module relu_maxpool_stream #(
    parameter int unsigned  DATA_W  = cnn_pkg::DATA_W,
    parameter int unsigned  IN_SIZE = cnn_pkg::CONV_OUT_SIZE,
    parameter int unsigned  NUM_CH  = cnn_pkg::CONV_NUM_FILTERS,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [DATA_W-1:0] out_data,
    output logic        [CH_W-1:0]   out_ch,
    output logic                     out_last
);

    import cnn_pkg::*;

    localparam int unsigned OUT_SIZE = IN_SIZE / 2;
    localparam int unsigned IDX_W    = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int unsigned ADDR_W   = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN_SIZE - 1);
    localparam logic [IDX_W-1:0] IDX_TAIL = IDX_W'(IN_SIZE - 2);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    logic [IDX_W-1:0] col_q, col_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [CH_W-1:0]  ch_q, ch_d;

    logic signed [DATA_W-1:0] hold_q;
    logic signed [DATA_W-1:0] pair;
    logic signed [DATA_W-1:0] win_max;
    logic        [DATA_W-1:0] buf_rd;
    logic        [ADDR_W-1:0] buf_addr;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic              out_last_q, out_last_d;

    logic accept;
    logic in_window;
    logic buf_we;
    logic win_done;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // The odd-size remainder row/column never joins a window.
    assign in_window = (col_q != IDX_LAST) && (row_q != IDX_LAST);
    assign buf_we    = accept && in_window && col_q[0] && !row_q[0];
    assign win_done  = accept && in_window && col_q[0] && row_q[0];

    assign buf_addr = ADDR_W'(col_q >> 1);
    assign pair     = smax(hold_q, in_data);
    assign win_max  = smax(buf_rd, pair);

    pool_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (OUT_SIZE)
    ) u_line_buf (
        .clk     (clk),
        .rstb    (rstb),
        .wr_en   (buf_we),
        .wr_addr (buf_addr),
        .wr_data (pair),
        .rd_addr (buf_addr),
        .rd_data (buf_rd)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        ch_d  = ch_q;
        if (accept) begin
            if (col_q == IDX_LAST) begin
                col_d = '0;
                if (row_q == IDX_LAST) begin
                    row_d = '0;
                    ch_d  = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // A load only happens when in_ready, so an unpopped result is never overwritten.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        if (win_done) begin
            out_valid_d = 1'b1;
            out_data_d  = win_max[DATA_W-1] ? '0 : win_max;
            out_ch_d    = ch_q;
            out_last_d  = (ch_q == CH_LAST) && (row_q == IDX_TAIL) && (col_q == IDX_TAIL);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            col_q       <= '0;
            row_q       <= '0;
            ch_q        <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            ch_q        <= ch_d;
            if (accept && in_window && !col_q[0]) begin
                hold_q <= in_data;
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Scoreboard bench for relu_maxpool_stream: stimulus pushes expected pooled
// results, a monitor pops them on every output handshake.
module tb_relu_maxpool_stream;

    localparam int N   = 13;
    localparam int NCH = 16;
    localparam int OS  = 6;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_ch;
    logic        out_last;

    always #5 clk = ~clk;

    relu_maxpool_stream dut (
        .clk       (clk),
        .rstb      (rstb),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  ch;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;
    int pops = 0;
    int tb_ch = 0;
    logic bp_en = 1'b0;
    logic bubbles_en = 1'b0;
    logic signed [31:0] img [N][N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Downstream ready, changed just after each rising edge.
    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin : monitor
        exp_t e;
        logic stall;
        logic [36:0] snap;
        stall = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (!rstb) begin
                stall = 1'b0;
            end else begin
                check("in_ready", {63'b0, in_ready}, {63'b0, (!out_valid || out_ready)});
                if (stall) begin
                    check("hold_valid", {63'b0, out_valid}, 64'd1);
                    check("hold_regs", {27'b0, out_data, out_ch, out_last}, {27'b0, snap});
                end
                if (out_valid && out_ready) begin
                    pops++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_output: got %0h, want no output", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", {32'b0, out_data}, {32'b0, e.data});
                        check("out_ch", {60'b0, out_ch}, {60'b0, e.ch});
                        check("out_last", {63'b0, out_last}, {63'b0, e.last});
                    end
                end
                stall = out_valid && !out_ready;
                snap = {out_data, out_ch, out_last};
            end
        end
    end

    task automatic push_exp(input logic [31:0] d, input int pr, input int pc);
        exp_t e;
        e.data = d;
        e.ch   = 4'(tb_ch);
        e.last = (tb_ch == NCH - 1) && (pr == OS - 1) && (pc == OS - 1);
        exp_q.push_back(e);
    endtask

    // Window model over the whole stored map; only windows finished within npix.
    task automatic push_model(input int npix);
        logic signed [31:0] m;
        for (int pr = 0; pr < OS; pr++) begin
            for (int pc = 0; pc < OS; pc++) begin
                if ((2 * pr + 1) * N + 2 * pc + 1 < npix) begin
                    m = img[2*pr][2*pc];
                    if (img[2*pr][2*pc+1] > m) m = img[2*pr][2*pc+1];
                    if (img[2*pr+1][2*pc] > m) m = img[2*pr+1][2*pc];
                    if (img[2*pr+1][2*pc+1] > m) m = img[2*pr+1][2*pc+1];
                    push_exp((m < 0) ? 32'd0 : m, pr, pc);
                end
            end
        end
    endtask

    task automatic send_pix(input logic [31:0] v);
        int waitc;
        waitc = 0;
        @(negedge clk);
        if (bubbles_en && $urandom_range(0, 7) == 0) @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready) begin
            waitc++;
            if (waitc > 200) begin
                $display("FAIL in_ready_timeout: got 0, want 1 within 200 cycles");
                bad++;
                total++;
                $display("test done: total=%0d bad=%0d", total, bad);
                $fatal(1, "stalled");
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_img(input int npix);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (r * N + c < npix) send_pix(img[r][c]);
            end
        end
        if (npix == N * N) tb_ch = (tb_ch + 1) % NCH;
    endtask

    task automatic fill(input logic signed [31:0] v);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) img[r][c] = v;
    endtask

    task automatic random_channel();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) img[r][c] = $urandom();
        push_model(N * N);
        send_img(N * N);
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || out_valid) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset();
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_out_data", {32'b0, out_data}, 64'd0);
        check("rst_out_ch", {60'b0, out_ch}, 64'd0);
        check("rst_out_last", {63'b0, out_last}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    endtask

    initial begin : stimulus
        int mark;
        repeat (3) @(negedge clk);
        check_reset();
        rstb = 1'b1;
        @(negedge clk);

        // ch0 ramp: window (pr,pc) max is pixel (2pr+1, 2pc+1) = 14 + 26pr + 2pc
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) img[r][c] = r * N + c;
        for (int pr = 0; pr < OS; pr++)
            for (int pc = 0; pc < OS; pc++) push_exp(32'(14 + 26 * pr + 2 * pc), pr, pc);
        send_img(N * N);

        // ch1 all negative: every output rectified to 0
        fill(-5);
        for (int pr = 0; pr < OS; pr++)
            for (int pc = 0; pc < OS; pc++) push_exp(32'd0, pr, pc);
        send_img(N * N);

        // ch2 negatives, one window with max positive, one with most negative
        fill(-100);
        img[4][6] = -7;  img[4][7] = -3;  img[5][6] = -9;  img[5][7] = -2;
        img[8][2] = -7;  img[8][3] = -3;  img[9][2] = 32'sh7FFF_FFFF;  img[9][3] = -2;
        img[0][0] = 32'sh8000_0000;
        for (int pr = 0; pr < OS; pr++)
            for (int pc = 0; pc < OS; pc++)
                push_exp((pr == 4 && pc == 1) ? 32'h7FFF_FFFF : 32'd0, pr, pc);
        send_img(N * N);

        // ch3 remainder row/column hold 1000 and must never reach the output
        fill(1);
        for (int i = 0; i < N; i++) begin
            img[N-1][i] = 1000;
            img[i][N-1] = 1000;
        end
        for (int pr = 0; pr < OS; pr++)
            for (int pc = 0; pc < OS; pc++) push_exp(32'd1, pr, pc);
        send_img(N * N);

        bp_en = 1'b1;
        bubbles_en = 1'b1;
        for (int ch = 4; ch < NCH; ch++) random_channel();
        drain();
        check("image1_outputs", 64'(pops), 64'd576);

        // partial image, then reset after 100 pixels of channel 3
        for (int ch = 0; ch < 3; ch++) random_channel();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) img[r][c] = $urandom();
        push_model(100);
        send_img(100);
        drain();
        @(negedge clk);
        rstb = 1'b0;
        tb_ch = 0;
        repeat (2) @(negedge clk);
        check_reset();
        rstb = 1'b1;

        mark = pops;
        for (int ch = 0; ch < NCH; ch++) random_channel();
        drain();
        check("image2_outputs", 64'(pops - mark), 64'd576);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
